// File: rtl/clip_edge_sequencer_pkg.sv
// Shared types, constants and the distance-slice helper for the clip sequencer.
package clip_pkg;

    localparam int unsigned VERTEX_WIDTH = 32;
    localparam int unsigned FRAC_BITS    = 16;
    localparam int unsigned MAX_VERTS    = 4;
    localparam int unsigned DIST_WIDTH   = VERTEX_WIDTH + 2;
    localparam int unsigned CNT_WIDTH    = 3;
    localparam int unsigned IDX_WIDTH    = 2;

    typedef logic signed [VERTEX_WIDTH-1:0] coord_t;
    typedef logic signed [DIST_WIDTH-1:0]   dist_t;

    typedef struct packed {
        coord_t w;
        coord_t z;
        coord_t y;
        coord_t x;
    } vertex_t;

    typedef struct packed {
        coord_t d;
        coord_t c;
        coord_t b;
        coord_t a;
    } plane_t;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_CLASSIFY   = 3'd1,
        ST_EDGE       = 3'd2,
        ST_ISECT_REQ  = 3'd3,
        ST_ISECT_WAIT = 3'd4,
        ST_EMIT       = 3'd5
    } state_t;

    // Full-precision signed product, keep the integer-aligned slice, sign-extend to sum width.
    function automatic dist_t dist_slice(coord_t coef, coord_t comp);
        logic signed [2*VERTEX_WIDTH-1:0] prod;
        prod = (2*VERTEX_WIDTH)'(coef) * (2*VERTEX_WIDTH)'(comp);
        return DIST_WIDTH'(coord_t'(prod >>> FRAC_BITS));
    endfunction

endpackage

// File: rtl/clip_edge_sequencer_if.sv
// Initiator-side link between the clip sequencer and the intersection unit.
interface clip_edge_sequencer_if;
    import clip_pkg::*;

    logic    isect_start_o;
    vertex_t isect_v1_o;
    vertex_t isect_v2_o;
    plane_t  isect_plane_o;
    logic    isect_done_i;
    coord_t  isect_x_i;
    coord_t  isect_y_i;
    coord_t  isect_z_i;
    coord_t  isect_w_i;

    modport master (
        output isect_start_o, isect_v1_o, isect_v2_o, isect_plane_o,
        input  isect_done_i, isect_x_i, isect_y_i, isect_z_i, isect_w_i
    );

    modport slave (
        input  isect_start_o, isect_v1_o, isect_v2_o, isect_plane_o,
        output isect_done_i, isect_x_i, isect_y_i, isect_z_i, isect_w_i
    );

endinterface

// File: rtl/clip_plane_dist.sv
// Combinational plane distance of one vertex and its inside (d >= 0) flag.
module clip_plane_dist
    import clip_pkg::*;
(
    input  vertex_t i_vtx,
    input  plane_t  i_plane,
    output logic    o_inside
);

    dist_t w_dist;

    // Four sliced products summed at extended width so the sum cannot wrap.
    always_comb begin
        w_dist = dist_slice(i_plane.a, i_vtx.x) + dist_slice(i_plane.b, i_vtx.y)
               + dist_slice(i_plane.c, i_vtx.z) + dist_slice(i_plane.d, i_vtx.w);
    end

    assign o_inside = (w_dist >= dist_t'(0));

endmodule

// File: rtl/clip_edge_sequencer.sv
// Single-plane Sutherland-Hodgman clip of one triangle with buffered polygon output.
module clip_edge_sequencer
    import clip_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  vertex_t              in_v0_i,
    input  vertex_t              in_v1_i,
    input  vertex_t              in_v2_i,
    input  coord_t               plane_a_i,
    input  coord_t               plane_b_i,
    input  coord_t               plane_c_i,
    input  coord_t               plane_d_i,
    clip_edge_sequencer_if.master isect,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output vertex_t              out_vertex_o,
    output logic                 out_last_o,
    output logic [CNT_WIDTH-1:0] out_count_o,
    output logic                 culled_o
);

    state_t                r_state, w_state_d;
    vertex_t               r_vtx [3];
    plane_t                r_plane;
    logic [2:0]            r_inside;
    logic [2:0]            w_inside;
    logic [1:0]            r_edge, w_edge_d, w_e_idx;
    vertex_t               r_buf [MAX_VERTS];
    vertex_t               w_buf_d [MAX_VERTS];
    logic [CNT_WIDTH-1:0]  r_cnt, w_cnt_d;
    logic [IDX_WIDTH-1:0]  r_rd, w_rd_d;
    logic                  r_done_q;
    logic                  r_in_ready, r_isect_start, r_out_valid, r_out_last, r_culled;
    vertex_t               r_isect_v1, r_isect_v2, r_out_vertex;
    logic [CNT_WIDTH-1:0]  r_out_count;
    logic                  w_load, w_we, w_adv, w_s_in, w_e_in;
    vertex_t               w_wdata, w_v1_d, w_v2_d, w_out_vertex_d;
    logic                  w_out_valid_d, w_out_last_d, w_culled_d;
    logic [CNT_WIDTH-1:0]  w_out_count_d;

    for (genvar k = 0; k < 3; k++) begin : g_dist
        clip_plane_dist u_dist (
            .i_vtx    (r_vtx[k]),
            .i_plane  (r_plane),
            .o_inside (w_inside[k])
        );
    end

    assign w_e_idx = (r_edge == 2'd2) ? 2'd0 : r_edge + 2'd1;
    assign w_s_in  = r_inside[r_edge];
    assign w_e_in  = r_inside[w_e_idx];

    // Next state, buffer writes and next values of all registered outputs.
    always_comb begin
        w_state_d      = r_state;
        w_edge_d       = r_edge;
        w_rd_d         = r_rd;
        w_cnt_d        = r_cnt;
        w_buf_d        = r_buf;
        w_v1_d         = r_isect_v1;
        w_v2_d         = r_isect_v2;
        w_load         = 1'b0;
        w_we           = 1'b0;
        w_wdata        = '0;
        w_adv          = 1'b0;
        w_out_valid_d  = r_out_valid;
        w_out_vertex_d = r_out_vertex;
        w_out_last_d   = r_out_last;
        w_out_count_d  = r_out_count;
        w_culled_d     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (in_valid_i && r_in_ready) begin
                    w_load    = 1'b1;
                    w_state_d = ST_CLASSIFY;
                    w_edge_d  = 2'd0;
                    w_rd_d    = '0;
                    w_cnt_d   = '0;
                end
            end
            ST_CLASSIFY: w_state_d = ST_EDGE;
            ST_EDGE: begin
                if (w_s_in) begin
                    w_we    = 1'b1;
                    w_wdata = r_vtx[r_edge];
                end
                if (w_s_in != w_e_in) begin
                    w_state_d = ST_ISECT_REQ;
                    w_v1_d    = w_s_in ? r_vtx[r_edge] : r_vtx[w_e_idx];
                    w_v2_d    = w_s_in ? r_vtx[w_e_idx] : r_vtx[r_edge];
                end else begin
                    w_adv = 1'b1;
                end
            end
            ST_ISECT_REQ: w_state_d = ST_ISECT_WAIT;
            ST_ISECT_WAIT: begin
                // Only a fresh rising edge counts; a level held over from before is ignored.
                if (isect.isect_done_i && !r_done_q) begin
                    w_we    = 1'b1;
                    w_wdata = '{w: isect.isect_w_i, z: isect.isect_z_i,
                                y: isect.isect_y_i, x: isect.isect_x_i};
                    w_adv   = 1'b1;
                end
            end
            ST_EMIT: begin
                // Empty polygon: this cycle carried the culled pulse.
                if (!r_out_valid) begin
                    w_state_d = ST_IDLE;
                end else if (out_ready_i) begin
                    if (r_out_last) begin
                        w_state_d      = ST_IDLE;
                        w_out_valid_d  = 1'b0;
                        w_out_last_d   = 1'b0;
                        w_out_count_d  = '0;
                        w_out_vertex_d = '0;
                    end else begin
                        w_rd_d         = r_rd + IDX_WIDTH'(1);
                        w_out_vertex_d = r_buf[w_rd_d];
                        w_out_last_d   = (CNT_WIDTH'(w_rd_d) == r_cnt - CNT_WIDTH'(1));
                    end
                end
            end
            default: w_state_d = ST_IDLE;
        endcase

        if (w_we) begin
            w_buf_d[IDX_WIDTH'(r_cnt)] = w_wdata;
            w_cnt_d                    = r_cnt + CNT_WIDTH'(1);
        end

        if (w_adv) begin
            if (r_edge == 2'd2) begin
                w_state_d = ST_EMIT;
                w_rd_d    = '0;
                if (w_cnt_d == '0) begin
                    w_culled_d    = 1'b1;
                    w_out_valid_d = 1'b0;
                end else begin
                    w_out_valid_d  = 1'b1;
                    w_out_vertex_d = w_buf_d[0];
                    w_out_last_d   = (w_cnt_d == CNT_WIDTH'(1));
                    w_out_count_d  = w_cnt_d;
                end
            end else begin
                w_state_d = ST_EDGE;
                w_edge_d  = r_edge + 2'd1;
            end
        end
    end

    // State register, control counters and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= ST_IDLE;
            r_edge        <= '0;
            r_cnt         <= '0;
            r_rd          <= '0;
            r_done_q      <= 1'b0;
            r_in_ready    <= 1'b1;
            r_isect_start <= 1'b0;
            r_isect_v1    <= '0;
            r_isect_v2    <= '0;
            r_out_valid   <= 1'b0;
            r_out_vertex  <= '0;
            r_out_last    <= 1'b0;
            r_out_count   <= '0;
            r_culled      <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_edge        <= w_edge_d;
            r_cnt         <= w_cnt_d;
            r_rd          <= w_rd_d;
            r_done_q      <= isect.isect_done_i;
            r_in_ready    <= (w_state_d == ST_IDLE);
            r_isect_start <= (w_state_d == ST_ISECT_REQ);
            r_isect_v1    <= w_v1_d;
            r_isect_v2    <= w_v2_d;
            r_out_valid   <= w_out_valid_d;
            r_out_vertex  <= w_out_vertex_d;
            r_out_last    <= w_out_last_d;
            r_out_count   <= w_out_count_d;
            r_culled      <= w_culled_d;
        end
    end

    // Triangle/plane capture, vertex classification and polygon buffer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_vtx    <= '{default: '0};
            r_plane  <= '0;
            r_inside <= '0;
            r_buf    <= '{default: '0};
        end else begin
            if (w_load) begin
                r_vtx[0] <= in_v0_i;
                r_vtx[1] <= in_v1_i;
                r_vtx[2] <= in_v2_i;
                r_plane  <= '{d: plane_d_i, c: plane_c_i, b: plane_b_i, a: plane_a_i};
            end
            if (r_state == ST_CLASSIFY) begin
                r_inside <= w_inside;
            end
            r_buf <= w_buf_d;
        end
    end

    assign in_ready_o          = r_in_ready;
    assign out_valid_o         = r_out_valid;
    assign out_vertex_o        = r_out_vertex;
    assign out_last_o          = r_out_last;
    assign out_count_o         = r_out_count;
    assign culled_o            = r_culled;
    assign isect.isect_start_o = r_isect_start;
    assign isect.isect_v1_o    = r_isect_v1;
    assign isect.isect_v2_o    = r_isect_v2;
    assign isect.isect_plane_o = r_plane;

endmodule

// File: tb/tb_clip_edge_sequencer.sv
// Directed bench for clip_edge_sequencer with a fixed-latency intersection responder.
module tb_clip_edge_sequencer;
    import clip_pkg::*;

    logic          clk;
    logic          rst_ni;
    logic          in_valid;
    logic          in_ready;
    vertex_t       v0, v1, v2;
    coord_t        pa, pb, pc, pd;
    logic          out_valid;
    logic          out_ready;
    vertex_t       out_vertex;
    logic          out_last;
    logic [2:0]    out_count;
    logic          culled;

    clip_edge_sequencer_if bus ();

    clip_edge_sequencer dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_v0_i      (v0),
        .in_v1_i      (v1),
        .in_v2_i      (v2),
        .plane_a_i    (pa),
        .plane_b_i    (pb),
        .plane_c_i    (pc),
        .plane_d_i    (pd),
        .isect        (bus),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_vertex_o (out_vertex),
        .out_last_o   (out_last),
        .out_count_o  (out_count),
        .culled_o     (culled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int      checks   = 0;
    int      failures = 0;
    int      nreq     = 0;
    vertex_t req_v1 [16];
    vertex_t req_v2 [16];
    vertex_t exp_q [$];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic vertex_t mkv(input int x, input int y, input int z, input int w);
        vertex_t v;
        v.x = x; v.y = y; v.z = z; v.w = w;
        return v;
    endfunction

    function automatic vertex_t ires(input int n);
        coord_t r;
        r = 32'(32'hAAAA_0000 + n);
        return '{w: r, z: r, y: r, x: r};
    endfunction

    // Intersection unit model: result 0xAAAA_0000+n four cycles after each start.
    initial begin
        bus.isect_done_i = 1'b0;
        bus.isect_x_i = '0; bus.isect_y_i = '0; bus.isect_z_i = '0; bus.isect_w_i = '0;
        forever begin
            @(negedge clk);
            if (bus.isect_start_o) begin
                req_v1[nreq] = bus.isect_v1_o;
                req_v2[nreq] = bus.isect_v2_o;
                repeat (4) @(negedge clk);
                bus.isect_x_i = 32'(32'hAAAA_0000 + nreq);
                bus.isect_y_i = 32'(32'hAAAA_0000 + nreq);
                bus.isect_z_i = 32'(32'hAAAA_0000 + nreq);
                bus.isect_w_i = 32'(32'hAAAA_0000 + nreq);
                bus.isect_done_i = 1'b1;
                @(negedge clk);
                bus.isect_done_i = 1'b0;
                nreq++;
            end
        end
    end

    task automatic send(input vertex_t a, input vertex_t b, input vertex_t c);
        v0 = a; v1 = b; v2 = c;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain(input int n, input int stall_at, input int stall_len);
        int i = 0;
        int stalls = 0;
        int cyc = 0;
        while (i < n && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (i == stall_at && stalls < stall_len) begin
                out_ready = 1'b0;
                stalls++;
            end else begin
                out_ready = 1'b1;
            end
            if (out_valid) begin
                chk($sformatf("beat%0d_vertex", i), 128'(out_vertex), 128'(exp_q[i]));
                chk($sformatf("beat%0d_last", i), 128'(out_last), 128'(i == n - 1));
                chk($sformatf("beat%0d_count", i), 128'(out_count), 128'(n));
                if (out_ready) i++;
            end
        end
        chk("beats_delivered", 128'(i), 128'(n));
        @(negedge clk);
        out_ready = 1'b0;
        chk("ready_after_emit", 128'(in_ready), 128'(1));
        chk("valid_after_emit", 128'(out_valid), 128'(0));
    endtask

    localparam coord_t ONE  = 32'h0001_0000;
    localparam coord_t TWO  = 32'h0002_0000;
    localparam coord_t MONE = 32'hFFFF_0000;
    localparam coord_t MTWO = 32'hFFFE_0000;

    initial begin
        vertex_t a, b, c;
        plane_t  exp_plane;
        int      base;
        int      wait_cyc;
        int      seen_valid;

        rst_ni = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        v0 = '0; v1 = '0; v2 = '0;
        pa = '0; pb = '0; pc = ONE; pd = '0;
        exp_plane = '{d: '0, c: ONE, b: '0, a: '0};
        repeat (2) @(negedge clk);

        chk("rst_in_ready", 128'(in_ready), 128'(1));
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_culled", 128'(culled), 128'(0));
        chk("rst_isect_start", 128'(bus.isect_start_o), 128'(0));
        chk("rst_out_count", 128'(out_count), 128'(0));
        chk("rst_isect_plane", 128'(bus.isect_plane_o), 128'(0));
        rst_ni = 1'b1;
        @(negedge clk);

        // All inside: latency to first beat and in-order output.
        a = mkv(32'h100, 32'h200, ONE, ONE);
        b = mkv(32'h101, 32'h201, TWO, ONE);
        c = mkv(32'h102, 32'h202, 32'h0003_0000, ONE);
        send(a, b, c);
        chk("inside_accepted", 128'(in_ready), 128'(0));
        repeat (3) @(negedge clk);
        chk("inside_valid_T4", 128'(out_valid), 128'(0));
        @(negedge clk);
        chk("inside_valid_T5", 128'(out_valid), 128'(1));
        exp_q = '{a, b, c};
        drain(3, -1, 0);
        chk("inside_no_requests", 128'(nreq), 128'(0));

        // All outside: culled pulse at T+5, ready again at T+6.
        a = mkv(32'h110, 0, MONE, ONE);
        b = mkv(32'h111, 0, MONE, ONE);
        c = mkv(32'h112, 0, MONE, ONE);
        send(a, b, c);
        repeat (3) @(negedge clk);
        chk("cull_T4_culled", 128'(culled), 128'(0));
        @(negedge clk);
        chk("cull_T5_culled", 128'(culled), 128'(1));
        chk("cull_T5_valid", 128'(out_valid), 128'(0));
        chk("cull_T5_ready", 128'(in_ready), 128'(0));
        @(negedge clk);
        chk("cull_T6_culled", 128'(culled), 128'(0));
        chk("cull_T6_ready", 128'(in_ready), 128'(1));
        chk("cull_no_requests", 128'(nreq), 128'(0));

        // Only v1 outside: quad v0, I0, I1, v2.
        base = nreq;
        a = mkv(32'h120, 1, ONE, ONE);
        b = mkv(32'h121, 2, MONE, ONE);
        c = mkv(32'h122, 3, TWO, ONE);
        send(a, b, c);
        exp_q = '{a, ires(base), ires(base + 1), c};
        drain(4, -1, 0);
        chk("v1out_nreq", 128'(nreq), 128'(base + 2));
        chk("v1out_req0_v1", 128'(req_v1[base]), 128'(a));
        chk("v1out_req0_v2", 128'(req_v2[base]), 128'(b));
        chk("v1out_req1_v1", 128'(req_v1[base + 1]), 128'(c));
        chk("v1out_req1_v2", 128'(req_v2[base + 1]), 128'(b));
        chk("isect_plane", 128'(bus.isect_plane_o), 128'(exp_plane));

        // v1 and v2 outside: triangle v0, I0, I1.
        base = nreq;
        a = mkv(32'h130, 4, ONE, ONE);
        b = mkv(32'h131, 5, MONE, ONE);
        c = mkv(32'h132, 6, MTWO, ONE);
        send(a, b, c);
        exp_q = '{a, ires(base), ires(base + 1)};
        drain(3, -1, 0);
        chk("v12out_nreq", 128'(nreq), 128'(base + 2));
        chk("v12out_req0_v1", 128'(req_v1[base]), 128'(a));
        chk("v12out_req0_v2", 128'(req_v2[base]), 128'(b));
        chk("v12out_req1_v1", 128'(req_v1[base + 1]), 128'(a));
        chk("v12out_req1_v2", 128'(req_v2[base + 1]), 128'(c));

        // Backpressure: ready low 5 cycles after the 2nd beat, output held.
        base = nreq;
        a = mkv(32'h140, 7, ONE, ONE);
        b = mkv(32'h141, 8, MONE, ONE);
        c = mkv(32'h142, 9, TWO, ONE);
        send(a, b, c);
        exp_q = '{a, ires(base), ires(base + 1), c};
        drain(4, 2, 5);

        // Reset during ISECT_WAIT; the late done pulse must be ignored.
        a = mkv(32'h150, 0, ONE, ONE);
        b = mkv(32'h151, 0, MONE, ONE);
        c = mkv(32'h152, 0, TWO, ONE);
        send(a, b, c);
        wait_cyc = 0;
        while (!bus.isect_start_o && wait_cyc < 50) begin
            @(negedge clk);
            wait_cyc++;
        end
        chk("rst_test_start_seen", 128'(bus.isect_start_o), 128'(1));
        @(negedge clk);
        rst_ni = 1'b0;
        #1;
        chk("midrst_in_ready", 128'(in_ready), 128'(1));
        chk("midrst_isect_start", 128'(bus.isect_start_o), 128'(0));
        @(negedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        seen_valid = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen_valid++;
        end
        chk("postrst_no_valid", 128'(seen_valid), 128'(0));
        chk("postrst_in_ready", 128'(in_ready), 128'(1));
        chk("postrst_done_consumed", 128'(nreq), 128'(base + 3));

        // Block still functional after the mid-flight reset.
        a = mkv(32'h160, 0, ONE, ONE);
        b = mkv(32'h161, 0, ONE, ONE);
        c = mkv(32'h162, 0, 32'h0000_0000, ONE);
        send(a, b, c);
        exp_q = '{a, b, c};
        drain(3, -1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clip_edge_sequencer.md
# clip_edge_sequencer

Per-plane Sutherland-Hodgman clip sequencer for one triangle. It sits in the preprocessing stage upstream of the `intersection` unit and drives that unit's start/done protocol as the initiator. For each triangle it classifies the three vertices against one plane and walks the three edges, issuing an intersection request on every inside/outside crossing. It buffers the resulting 0, 3 or 4 vertices and streams them out with a valid/ready handshake.

## Interface
- VERTEX_WIDTH, 32, width of each vertex component and plane coefficient (signed fixed point)
- FRAC_BITS, 16, fractional bits of the fixed-point format
- MAX_VERTS, 4, output buffer depth; fixed at 4 (one plane clipping a triangle)

- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- in_valid_i  in  1  triangle and plane valid
- in_ready_o  out  1  block is idle and accepts a triangle
- in_v0_i, in_v1_i, in_v2_i  in  4*VERTEX_WIDTH each  packed vertex {w,z,y,x}, signed
- plane_a_i, plane_b_i, plane_c_i, plane_d_i  in  VERTEX_WIDTH each  plane coefficients, signed
- isect_start_o  out  1  one-cycle request pulse to the intersection unit
- isect_v1_o, isect_v2_o  out  4*VERTEX_WIDTH each  inside vertex and outside vertex; held stable from start until done
- isect_plane_o  out  4*VERTEX_WIDTH  registered plane {d,c,b,a}
- isect_done_i  in  1  intersection result ready; rising edge is significant
- isect_x_i, isect_y_i, isect_z_i, isect_w_i  in  VERTEX_WIDTH each  intersection point
- out_valid_o  out  1  output vertex valid
- out_ready_i  in  1  downstream accepts
- out_vertex_o  out  4*VERTEX_WIDTH  clipped vertex {w,z,y,x}
- out_last_o  out  1  final vertex of the polygon
- out_count_o  out  3  polygon vertex count (3 or 4); valid whenever out_valid_o is high
- culled_o  out  1  one-cycle pulse when all three vertices are outside

## Operation
- States:
  - IDLE: wait for a triangle.
  - CLASSIFY: compute the three plane distances.
  - EDGE: evaluate the current edge.
  - ISECT_REQ: issue the intersection request.
  - ISECT_WAIT: wait for the result.
  - EMIT: stream the buffered polygon.
- Transitions:
  - IDLE→CLASSIFY on in_valid_i & in_ready_o. The three vertices and the plane are registered.
  - CLASSIFY: distance d_k = sum of (coef × component) products. Each product is signed 2·VERTEX_WIDTH, bits [VERTEX_WIDTH-1+FRAC_BITS:FRAC_BITS] are kept, and the four slices are sign-extended and summed at VERTEX_WIDTH+2 bits. Vertex k is inside iff d_k ≥ 0. Go to EDGE with edge index e=0.
  - EDGE, edge (S=v_e, E=v_(e+1 mod 3)):
    - If S is inside, write S to the buffer.
    - If inside(S) ≠ inside(E), go to ISECT_REQ. isect_v1_o is the inside vertex and isect_v2_o is the outside vertex.
    - Otherwise advance e. A vertex write and a request can occur on the same edge; the write happens first.
  - ISECT_REQ: isect_start_o=1 for exactly one cycle, then go to ISECT_WAIT.
  - ISECT_WAIT: on the first rising edge of isect_done_i (registered previous value), write {w,z,y,x} to the buffer and advance e. A level that is already high on entry is not accepted.
  - After e=2 completes: count 0 → culled_o pulse and go to IDLE; otherwise go to EMIT.
  - EMIT: present buffer entries in write order. A beat transfers on out_valid_o & out_ready_i. out_last_o is high on entry count-1. After the last transfer, go to IDLE.
- A vertex with d=0 counts as inside. An outside→on-plane edge therefore yields a duplicate vertex (t=0). This is not suppressed.
- Vertex order is S-H order starting at v0.

## Timing
- Reset values: in_ready_o=1; all other outputs 0; state IDLE; buffer count 0.
- Accept at cycle T, CLASSIFY at T+1, edges start at T+2. Each edge with no crossing takes 1 cycle.
- All-inside triangle: first out_valid_o at T+5.
- Each crossing adds 2 cycles plus the intersection latency.
- in_ready_o is high only in IDLE. A new triangle is accepted in the cycle after the final out transfer or the culled_o pulse.
- While out_ready_i is low, out_vertex_o, out_last_o and out_count_o are held stable.
- Reset asserted in any state returns the block to IDLE immediately. isect_start_o drops and any pending result is discarded. A late isect_done_i after reset is ignored, because the block is not in ISECT_WAIT.

## Structure
- Package clip_pkg holds:
  - vertex_t packed struct {w,z,y,x}
  - the state enum
  - the MAX_VERTS constant
  - the distance-slice helper function
- Sub-module clip_plane_dist: combinational 4-term dot product with the slice/sum rule above, instantiated three times.

## Test plan
All scenarios use plane a=b=d=0, c=0x0001_0000 (inside iff z≥0). The bench model of the intersection unit returns result 0xAAAA_0000+n after 4 cycles.
- All inside, z = 1.0, 2.0, 3.0 → outputs v0, v1, v2; out_count=3; out_last on the 3rd; no isect_start_o.
- All outside, z = -1.0 each → no out_valid_o; one culled_o pulse at T+5; in_ready_o high at T+6.
- Only v1 outside → 2 requests with (v1,v2) = (v0,v1) then (v2,v1) → output v0, I0, I1, v2; out_count=4.
- v1 and v2 outside → requests (v0,v1) then (v0,v2) → output v0, I0, I1; out_count=3.
- out_ready_i low for 5 cycles after the 2nd beat → vertex stays stable; all beats delivered exactly once.
- rst_ni low during ISECT_WAIT, then done pulses → in IDLE, in_ready_o=1, no out_valid_o.
